// File: rtl/csa_pkg.sv
// csa_pkg: shared defaults, stage-1 payload element types and sizing helper for pipelined_csa_adder
package csa_pkg;
  localparam int CSA_WIDTH = 64;
  localparam int CSA_BLOCK = 16;
  typedef struct packed {
    logic cout0;
    logic cout1;
  } carry_pair_t;
  typedef struct packed {
    logic a_msb;
    logic b_msb;
  } msb_pair_t;
  function automatic int nblk(input int width, input int block);
    return width / block;
  endfunction
endpackage

// File: rtl/pipelined_csa_adder_if.sv
// pipelined_csa_adder_if: operand/result handshake bundle; ovf exists only when CSA_OVERFLOW_EN is defined
interface pipelined_csa_adder_if #(parameter int WIDTH = csa_pkg::CSA_WIDTH);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic c_in;
  logic sub;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] sum;
  logic c_out;
`ifdef CSA_OVERFLOW_EN
  logic ovf;
  modport master(output in_valid, a, b, c_in, sub, out_ready, input in_ready, out_valid, sum, c_out, ovf);
  modport slave(input in_valid, a, b, c_in, sub, out_ready, output in_ready, out_valid, sum, c_out, ovf);
`else
  modport master(output in_valid, a, b, c_in, sub, out_ready, input in_ready, out_valid, sum, c_out);
  modport slave(input in_valid, a, b, c_in, sub, out_ready, output in_ready, out_valid, sum, c_out);
`endif
endinterface

// File: rtl/csa_block_pair.sv
// csa_block_pair: BLOCK-bit dual adder producing results for carry-in 0 and carry-in 1
module csa_block_pair #(parameter int BLOCK = 16) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  output logic [BLOCK-1:0] sum0,
  output logic [BLOCK-1:0] sum1,
  output logic             cout0,
  output logic             cout1
);
  localparam logic [BLOCK:0] ONE = 1;
  assign {cout0, sum0} = {1'b0, a} + {1'b0, b};
  assign {cout1, sum1} = {1'b0, a} + {1'b0, b} + ONE;
endmodule

// File: rtl/pipelined_csa_adder.sv
// pipelined_csa_adder: two-stage carry-select adder/subtractor with valid/ready flow control (ovf via CSA_OVERFLOW_EN)
module pipelined_csa_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int BLOCK = CSA_BLOCK
) (
  input logic clk,
  input logic rst,
  pipelined_csa_adder_if.slave bus
);
  localparam int NBLK = nblk(WIDTH, BLOCK);
  typedef struct packed {
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    carry_pair_t [NBLK-1:0] cy;
  } s1_pay_t;
  logic [WIDTH-1:0] b_eff, s0_n, s1_n, sum_n, sum_q;
  logic [NBLK-1:0] c0_n, c1_n;
  logic cin_eff, s1_valid, s2_adv, s1_adv, acc, sel, out_valid_q, c_out_q;
  s1_pay_t pay_n, pay_q;
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.c_in ^ bus.sub;
  assign s2_adv = !out_valid_q || bus.out_ready;
  assign s1_adv = s1_valid && s2_adv;
  assign bus.in_ready = !s1_valid || s2_adv;
  assign acc = bus.in_valid && bus.in_ready;
  assign {c0_n[0], s0_n[BLOCK-1:0]} = {1'b0, bus.a[BLOCK-1:0]} + {1'b0, b_eff[BLOCK-1:0]} + {{BLOCK{1'b0}}, cin_eff};
  assign c1_n[0] = 1'b0;
  assign s1_n[BLOCK-1:0] = '0;
  for (genvar k = 1; k < NBLK; k++) begin : g_blk
    csa_block_pair #(.BLOCK(BLOCK)) u_pair (
      .a    (bus.a[k*BLOCK +: BLOCK]),
      .b    (b_eff[k*BLOCK +: BLOCK]),
      .sum0 (s0_n[k*BLOCK +: BLOCK]),
      .sum1 (s1_n[k*BLOCK +: BLOCK]),
      .cout0(c0_n[k]),
      .cout1(c1_n[k])
    );
  end
  // Pack the speculative block results into the stage-1 payload
  always_comb begin
    pay_n.s0 = s0_n;
    pay_n.s1 = s1_n;
    for (int i = 0; i < NBLK; i++) pay_n.cy[i] = {c0_n[i], c1_n[i]};
  end
  // Select chain: block 0 sees a fixed 0 select so it always takes its real cin_eff result
  always_comb begin
    sel = 1'b0;
    sum_n = '0;
    for (int i = 0; i < NBLK; i++) begin
      sum_n[i*BLOCK +: BLOCK] = sel ? pay_q.s1[i*BLOCK +: BLOCK] : pay_q.s0[i*BLOCK +: BLOCK];
      sel = sel ? pay_q.cy[i].cout1 : pay_q.cy[i].cout0;
    end
  end
  // Stage-1 payload only loads on accept, so its contents need no reset
  always_ff @(posedge clk) if (acc) pay_q <= pay_n;
  // Stage-1 occupancy: filled on accept, emptied when it moves to the output
  always_ff @(posedge clk or posedge rst)
    if (rst) s1_valid <= 1'b0;
    else s1_valid <= acc ? 1'b1 : (s1_adv ? 1'b0 : s1_valid);
  // Output register holds steady whenever the consumer stalls a valid result
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q <= '0;
      c_out_q <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        sum_q <= sum_n;
        c_out_q <= sel;
      end
    end
  assign bus.out_valid = out_valid_q;
  assign bus.sum = sum_q;
  assign bus.c_out = c_out_q;
`ifdef CSA_OVERFLOW_EN
  msb_pair_t msb_q;
  logic ovf_q;
  // Operand sign bits travel with the stage-1 payload
  always_ff @(posedge clk) if (acc) msb_q <= {bus.a[WIDTH-1], b_eff[WIDTH-1]};
  // Overflow is carry-into-MSB xor carry-out, registered with the sum
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf_q <= 1'b0;
    else if (s1_adv) ovf_q <= msb_q.a_msb ^ msb_q.b_msb ^ sum_n[WIDTH-1] ^ sel;
  assign bus.ovf = ovf_q;
`endif
endmodule
